spmv_opt_dispatch: RTL and testbench
====================================

# spmv_opt_dispatch

Command dispatcher that feeds the SpMV processing-element opcode chain. It buffers 64-bit host command words in a small FIFO and drives them one per cycle onto `opt_out`, which connects to `opt_in` of the first PE. It enforces host barriers by stalling until the PE chain's aggregated busy signal clears, and exposes an idle/busy summary back to the host.

## Interface
- `FIFO_DEPTH`, default 16: command FIFO entries; must be a power of 2, at least 2.
- `BUSY_LAT`, default 8: cycles from an opcode leaving `opt_out` until its effect is visible on `busy_in`; range 1..255.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_push`  in  1  write `cmd_d` into the FIFO this cycle.
- `cmd_d`  in  64  command word. Fields: [6:0] opcode, [11] broadcast, [10:7] PE id, [13:12] register index, [63:14] data.
- `cmd_full`  out  1  FIFO full; pushes made while high are dropped.
- `opt_out`  out  64  registered opcode to the first PE. All-zero means OP_NOP.
- `busy_in`  in  1  OR of all PE busy outputs, as seen at the end of the chain.
- `busy_out`  out  1  dispatcher or chain busy.
- `overflow`  out  1  sticky flag: a push was dropped.
- `issued_cnt`  out  32  count of words driven onto `opt_out`; wraps modulo 2^32.

## Operation
- Opcodes: OP_NOP=0, OP_RST=1, OP_STEADY=2, OP_LD=3, OP_WAIT=7'h7F.
- OP_WAIT is local to the dispatcher and is never forwarded. All other words are forwarded verbatim, including unknown opcodes.
- The FIFO is show-ahead. Occupancy is a counter of width log2(FIFO_DEPTH)+1.
- `cmd_full` = (count == FIFO_DEPTH), computed from the registered count.
- A push while full is dropped and sets `overflow`, even if a pop happens in the same cycle.
- The FIFO supports a simultaneous push and pop when not full; the count is unchanged.
- State machine (2 states):
  - RUN: if the FIFO is non-empty, pop the head.
    - If the head opcode is not OP_WAIT: `opt_out` <= head, `issued_cnt` += 1, holdoff <= BUSY_LAT.
    - If the head opcode is OP_WAIT: `opt_out` <= 0 and go to WAIT.
    - If the FIFO is empty: `opt_out` <= 0.
  - WAIT: no pops; `opt_out` <= 0. Return to RUN in the cycle where holdoff == 0 and `busy_in` == 0; no pop happens in that transition cycle.
- Holdoff counter: 8 bits. It decrements each cycle while non-zero and saturates at 0. A reload on forward takes priority over the decrement.
- `busy_out` = (count != 0) | (state == WAIT) | (holdoff != 0) | `busy_in`. This is combinational from registered state and `busy_in`.
- OP_RST forwarded to the PEs does not reset the dispatcher. It is treated like any other forwarded word.

## Timing
- Reset values: `opt_out`=0, `cmd_full`=0, `overflow`=0, `issued_cnt`=0, FIFO empty, holdoff=0, state RUN. `busy_out` then equals `busy_in`.
- Reset mid-operation flushes all FIFO contents. Any WAIT in progress is abandoned. Nothing already driven is replayed.
- Latency: a push in cycle t makes the word eligible for pop in t+1; it appears on `opt_out` in t+2.
- Throughput is 1 word per cycle with back-to-back forwarding. `opt_out` holds each word for exactly one cycle, then goes to 0 unless the next word follows immediately.
- An OP_WAIT popped in cycle t places the dispatcher in WAIT from t+1.
  - The minimum WAIT length is max(holdoff remaining, 1) cycles, plus the time until `busy_in` is low.
  - The next word pops in the cycle after the exit condition holds.
- Consecutive OP_WAITs each cost at least one WAIT cycle plus the return to RUN.
- `issued_cnt` wraps from 0xFFFFFFFF to 0 with no flag.

## Test plan
- Reset, then push 3 OP_LD words (PE 2, register 1, data 0x123) in cycles 0..2. Expect them on `opt_out` in cycles 2..4, `opt_out`=0 in cycle 5, `issued_cnt`=3, and `busy_out` low BUSY_LAT cycles after the last word (with `busy_in`=0).
- Push OP_STEADY, OP_WAIT, OP_LD with BUSY_LAT=8 and hold `busy_in` high for 20 cycles after OP_STEADY issues. Expect OP_LD not driven until the cycle after `busy_in` falls, and OP_WAIT never seen on `opt_out`.
- With `busy_in`=0 throughout, push OP_LD then OP_WAIT. Expect the next word delayed by exactly BUSY_LAT + 1 extra cycles: the holdoff is respected even though busy never rises.
- Block pops with a leading OP_WAIT and `busy_in`=1, then push 17 words. Expect `cmd_full` after the 16th, the 17th dropped, `overflow`=1 and sticky. After releasing `busy_in`, expect exactly 15 forwarded words.
- Assert `rst` while in WAIT with 5 words queued. Expect the next cycle to show `opt_out`=0, count 0, `issued_cnt`=0, `overflow`=0, and no queued word ever emitted.
- Preload `issued_cnt` near wrap via 2^32−2 forwarded NOPs (or force). Forward 3 words and expect a final count of 1.

Source files
------------

// File: rtl/spmv_opt_dispatch.sv
// spmv_opt_dispatch: buffers host command words and feeds them, one per
// cycle, into the PE opcode chain. OP_WAIT words are consumed locally and
// act as barriers: the dispatcher holds until the holdoff window from the
// last forwarded word has expired and the chain reports not busy.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  RUN   | pop and forward the FIFO head every cycle it is non-empty
//  WAIT  | barrier; no pops until holdoff == 0 and busy_in == 0
module spmv_opt_dispatch #(
  parameter int FIFO_DEPTH = 16,
  parameter int BUSY_LAT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_push,
  input  logic [63:0] cmd_d,
  output logic        cmd_full,
  output logic [63:0] opt_out,
  input  logic        busy_in,
  output logic        busy_out,
  output logic        overflow,
  output logic [31:0] issued_cnt
);

  localparam int            AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]    BUSY_LAT_C = 8'(BUSY_LAT);
  localparam logic [6:0]    OP_WAIT    = 7'h7F;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t          state;
  logic [63:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [7:0]      holdoff;

  logic            push_ok;
  logic            pop;
  logic            fifo_empty;
  logic [63:0]     head;
  logic            head_is_wait;

  // Full/empty decode comes straight from the registered occupancy.
  assign cmd_full     = (count == DEPTH_C);
  assign fifo_empty   = (count == '0);
  assign push_ok      = cmd_push & ~cmd_full;
  assign pop          = (state == ST_RUN) & ~fifo_empty;
  assign head         = mem[rd_ptr];
  assign head_is_wait = (head[6:0] == OP_WAIT);

  assign busy_out = ~fifo_empty | (state == ST_WAIT) | (holdoff != 8'd0) | busy_in;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= cmd_d;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A full FIFO refuses the push even if a pop frees a slot this cycle.
      if (cmd_push && cmd_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Dispatch FSM with registered opcode output, issue counter and holdoff timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      opt_out    <= '0;
      issued_cnt <= '0;
      holdoff    <= '0;
    end else begin
      opt_out <= '0;
      if (holdoff != 8'd0) begin
        holdoff <= holdoff - 8'd1;
      end
      case (state)
        ST_RUN: begin
          if (pop) begin
            if (head_is_wait) begin
              state <= ST_WAIT;
            end else begin
              opt_out    <= head;
              issued_cnt <= issued_cnt + 32'd1;
              holdoff    <= BUSY_LAT_C;
            end
          end
        end
        ST_WAIT: begin
          if ((holdoff == 8'd0) && !busy_in) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_opt_dispatch.sv
// Directed bench for spmv_opt_dispatch (FIFO_DEPTH=16, BUSY_LAT=8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_spmv_opt_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_push;
  logic [63:0] cmd_d;
  logic        cmd_full;
  logic [63:0] opt_out;
  logic        busy_in;
  logic        busy_out;
  logic        overflow;
  logic [31:0] issued_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] OP_STEADY = 7'd2;
  localparam logic [6:0] OP_LD     = 7'd3;
  localparam logic [6:0] OP_WAIT   = 7'h7F;

  always #5 clk = ~clk;

  spmv_opt_dispatch #(.FIFO_DEPTH(16), .BUSY_LAT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_push   (cmd_push),
    .cmd_d      (cmd_d),
    .cmd_full   (cmd_full),
    .opt_out    (opt_out),
    .busy_in    (busy_in),
    .busy_out   (busy_out),
    .overflow   (overflow),
    .issued_cnt (issued_cnt)
  );

  function automatic logic [63:0] mk(input logic [6:0] op, input logic [3:0] pe,
                                     input logic [1:0] rg, input logic [49:0] data);
    return {data, rg, 1'b0, pe, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    cmd_push = 1'b0;
    cmd_d    = '0;
    busy_in  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [63:0] w0, w1, w2;
  logic [63:0] exp_w;
  int          nfwd;

  initial begin
    // ---- reset state and back-to-back forwarding ----
    do_reset();
    chk("rst_opt_out", opt_out, 64'd0);
    chk("rst_cmd_full", cmd_full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_issued", issued_cnt, 32'd0);
    chk("rst_busy_lo", busy_out, 1'b0);
    busy_in = 1'b1;
    #1;
    chk("rst_busy_follows_in", busy_out, 1'b1);
    busy_in = 1'b0;
    #1;

    w0 = mk(OP_LD, 4'd2, 2'd1, 50'h123);
    w1 = mk(OP_LD, 4'd2, 2'd1, 50'h124);
    w2 = mk(OP_LD, 4'd2, 2'd1, 50'h125);
    chk("t1_word_enc", w0, 64'h0000_0000_0048_D103);
    cmd_push = 1'b1; cmd_d = w0;            // cycle 0
    step();
    cmd_d = w1;                             // cycle 1
    step();
    cmd_d = w2;                             // cycle 2
    chk("t1_out_c2", opt_out, w0);
    step();
    cmd_push = 1'b0;                        // cycle 3
    chk("t1_out_c3", opt_out, w1);
    step();
    chk("t1_out_c4", opt_out, w2);         // cycle 4
    step();
    chk("t1_out_c5", opt_out, 64'd0);      // cycle 5
    chk("t1_issued", issued_cnt, 32'd3);
    for (int c = 6; c <= 11; c++) step();
    chk("t1_busy_c11", busy_out, 1'b1);    // holdoff == 1
    step();
    chk("t1_busy_c12", busy_out, 1'b0);    // holdoff == 0, 8 cycles after last word

    // ---- barrier held by busy_in ----
    do_reset();
    w0 = mk(OP_STEADY, 4'd0, 2'd0, 50'h0);
    w1 = mk(OP_WAIT, 4'd0, 2'd0, 50'h0);
    w2 = mk(OP_LD, 4'd5, 2'd3, 50'h3_ABCD);
    cmd_push = 1'b1; cmd_d = w0;            // cycle 0
    step();
    cmd_d = w1;                             // cycle 1
    step();
    cmd_d = w2;                             // cycle 2
    chk("t2_steady_out", opt_out, w0);
    busy_in = 1'b1;                         // high for cycles 2..21
    step();
    cmd_push = 1'b0;
    for (int c = 3; c <= 23; c++) begin
      if (c == 22) begin
        busy_in = 1'b0;
        #1;
      end
      chk("t2_gap_zero", opt_out, 64'd0);
      step();
    end
    chk("t2_ld_out_c24", opt_out, w2);     // cycle 24
    chk("t2_issued", issued_cnt, 32'd2);

    // ---- holdoff honoured with busy_in low ----
    do_reset();
    w0 = mk(OP_LD, 4'd1, 2'd0, 50'h11);
    w1 = mk(OP_WAIT, 4'd0, 2'd0, 50'h0);
    w2 = mk(OP_LD, 4'd1, 2'd2, 50'h22);
    cmd_push = 1'b1; cmd_d = w0;            // cycle 0
    step();
    cmd_d = w1;                             // cycle 1
    step();
    cmd_d = w2;                             // cycle 2
    chk("t3_first_out", opt_out, w0);
    step();
    cmd_push = 1'b0;
    for (int c = 3; c <= 11; c++) begin
      chk("t3_gap_zero", opt_out, 64'd0);
      step();
    end
    chk("t3_second_out_c12", opt_out, w2);

    // ---- fill to full, overflow, drain ----
    do_reset();
    busy_in = 1'b1;
    cmd_push = 1'b1; cmd_d = mk(OP_WAIT, 4'd0, 2'd0, 50'h0);   // cycle 0
    step();
    cmd_push = 1'b0;                                            // cycle 1
    step();
    for (int i = 0; i <= 16; i++) begin                         // cycles 2..18
      cmd_push = 1'b1;
      cmd_d = (i == 0) ? mk(OP_WAIT, 4'd0, 2'd0, 50'h0)
                       : mk(OP_LD, i[3:0], 2'd0, 50'(100 + i));
      if (i == 15) chk("t4_not_full_yet", cmd_full, 1'b0);
      if (i == 16) begin
        chk("t4_full", cmd_full, 1'b1);
        chk("t4_no_ovf_yet", overflow, 1'b0);
      end
      step();
    end
    cmd_push = 1'b0;
    chk("t4_overflow", overflow, 1'b1);
    chk("t4_still_full", cmd_full, 1'b1);
    step();
    busy_in = 1'b0;
    nfwd = 0;
    for (int c = 0; c < 40; c++) begin
      if (opt_out != 64'd0) begin
        exp_w = mk(OP_LD, 4'(nfwd + 1), 2'd0, 50'(100 + nfwd + 1));
        if (nfwd < 15) chk("t4_fwd_word", opt_out, exp_w);
        nfwd++;
      end
      step();
    end
    chk("t4_fwd_count", 64'(nfwd), 64'd15);
    chk("t4_issued", issued_cnt, 32'd15);
    chk("t4_overflow_sticky", overflow, 1'b1);
    chk("t4_full_clear", cmd_full, 1'b0);
    chk("t4_idle", busy_out, 1'b0);

    // ---- reset in WAIT with words queued ----
    do_reset();
    busy_in = 1'b1;
    cmd_push = 1'b1; cmd_d = mk(OP_LD, 4'd3, 2'd0, 50'h77);    // cycle 0
    step();
    cmd_d = mk(OP_WAIT, 4'd0, 2'd0, 50'h0);                    // cycle 1
    step();
    for (int i = 0; i < 5; i++) begin                          // cycles 2..6
      cmd_d = mk(OP_LD, 4'd4, 2'd1, 50'(200 + i));
      step();
    end
    cmd_push = 1'b0;                                           // cycle 7
    chk("t5_issued_before", issued_cnt, 32'd1);
    chk("t5_busy_before", busy_out, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;                                                // cycle 8
    chk("t5_opt_out", opt_out, 64'd0);
    chk("t5_issued", issued_cnt, 32'd0);
    chk("t5_overflow", overflow, 1'b0);
    chk("t5_cmd_full", cmd_full, 1'b0);
    busy_in = 1'b0;
    #1;
    chk("t5_busy_flushed", busy_out, 1'b0);
    for (int c = 0; c < 20; c++) begin
      chk("t5_no_replay", opt_out, 64'd0);
      step();
    end
    chk("t5_issued_after", issued_cnt, 32'd0);

    // ---- issue counter wrap ----
    do_reset();
    w0 = mk(OP_LD, 4'd6, 2'd2, 50'h501);
    w1 = mk(7'h55, 4'd6, 2'd2, 50'h502);     // unknown opcode forwarded verbatim
    w2 = mk(OP_LD, 4'd6, 2'd2, 50'h503);
    force dut.issued_cnt = 32'hFFFF_FFFE;
    cmd_push = 1'b1; cmd_d = w0;            // cycle 0
    step();
    release dut.issued_cnt;
    cmd_d = w1;                             // cycle 1
    chk("t6_preload", issued_cnt, 32'hFFFF_FFFE);
    step();
    cmd_d = w2;                             // cycle 2
    chk("t6_cnt_ffffffff", issued_cnt, 32'hFFFF_FFFF);
    chk("t6_out0", opt_out, w0);
    step();
    cmd_push = 1'b0;                        // cycle 3
    chk("t6_cnt_wrap0", issued_cnt, 32'd0);
    chk("t6_out_unknown", opt_out, w1);
    step();
    chk("t6_cnt_final", issued_cnt, 32'd1); // cycle 4
    chk("t6_out2", opt_out, w2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
